// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, one bit per cycle.
// Multiply uses shift-add on operand magnitudes with a final sign fix.
// Divide uses restoring division on magnitudes with a final sign fix.
// Every accepted operation takes exactly XLEN cycles in CALC, then one DONE cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Latched operation context.
  logic [2:0]      op_reg;
  // Multiply: acc = running high word, shf = multiplier shifting into low word.
  // Divide:   acc = partial remainder,  shf = dividend shifting out / quotient in.
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] shf_reg;
  logic [XLEN-1:0] opnd_reg;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] dividend_reg;  // raw op_a, returned as remainder on divide by zero
  logic            neg_reg;       // product / quotient must be negated
  logic            rem_neg_reg;   // remainder takes the dividend's sign
  logic            div_zero_reg;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] result_reg;

  logic accept;
  logic last_step;

  // Operand signedness and magnitudes for the op being requested.
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  // Iteration datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc, mul_shf;
  logic [XLEN:0]     div_shifted;
  logic [XLEN-1:0]   div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   div_acc, div_shf;
  logic [XLEN-1:0]   acc_next, shf_next;

  // Final result formation.
  logic [2*XLEN-1:0] prod_mag, prod_val;
  logic [XLEN-1:0]   quo_val, rem_val;
  logic [XLEN-1:0]   result_next;

  assign accept    = (state_reg == IDLE) && start;
  assign last_step = (state_reg == CALC) && (cnt_reg == LAST);
  assign result    = result_reg;

  // Decode which operands are treated as signed and take magnitudes.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end  // MULH
      3'b010:         begin a_signed = 1'b1; end                    // MULHSU
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end  // DIV, REM
      default:        begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
    a_neg = a_signed & op_a[XLEN-1];
    b_neg = b_signed & op_b[XLEN-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // One multiply step and one restoring-divide step; the op selects which applies.
  always_comb begin
    mul_sum     = {1'b0, acc_reg} + (shf_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    mul_acc     = mul_sum[XLEN:1];
    mul_shf     = {mul_sum[0], shf_reg[XLEN-1:1]};

    div_shifted = {acc_reg, shf_reg[XLEN-1]};
    div_ok      = (div_shifted >= {1'b0, opnd_reg});
    // When the subtraction succeeds the true difference fits in XLEN bits.
    div_diff    = div_shifted[XLEN-1:0] - opnd_reg;
    div_acc     = div_ok ? div_diff : div_shifted[XLEN-1:0];
    div_shf     = {shf_reg[XLEN-2:0], div_ok};

    if (op_reg[2]) begin
      acc_next = div_acc;
      shf_next = div_shf;
    end else begin
      acc_next = mul_acc;
      shf_next = mul_shf;
    end
  end

  // Sign-correct the final step's values and select the requested word.
  always_comb begin
    prod_mag = {mul_acc, mul_shf};
    prod_val = neg_reg ? -prod_mag : prod_mag;
    quo_val  = neg_reg ? -div_shf : div_shf;
    rem_val  = rem_neg_reg ? -div_acc : div_acc;
    case (op_reg)
      3'b000:                 result_next = prod_val[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_next = prod_val[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_next = div_zero_reg ? {XLEN{1'b1}} : quo_val;
      default:                result_next = div_zero_reg ? dividend_reg : rem_val;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, iterate in CALC, capture result on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg       <= 3'b000;
      acc_reg      <= '0;
      shf_reg      <= '0;
      opnd_reg     <= '0;
      dividend_reg <= '0;
      neg_reg      <= 1'b0;
      rem_neg_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      cnt_reg      <= '0;
      result_reg   <= '0;
    end else if (accept) begin
      op_reg       <= funct3;
      acc_reg      <= '0;
      shf_reg      <= funct3[2] ? a_mag : b_mag;
      opnd_reg     <= funct3[2] ? b_mag : a_mag;
      dividend_reg <= op_a;
      neg_reg      <= a_neg ^ b_neg;
      rem_neg_reg  <= a_neg;
      div_zero_reg <= (op_b == '0);
      cnt_reg      <= '0;
    end else if (state_reg == CALC) begin
      acc_reg <= acc_next;
      shf_reg <= shf_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_step) result_reg <= result_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model, including timing, latching, and reset abort.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .funct3(funct3),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 0;
    case (f)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb;
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub;
      end
    endcase
    pu = p;
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) return pu[63:32];
    return pu[31:0];
  endfunction

  // Issue one operation and check busy/done every cycle plus result timing.
  // With noisy set, start stays high with changing operands through CALC and DONE.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit noisy);
    logic [31:0] exp;
    exp    = model(f, a, b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk); #1;
    check({tag, ":state@N"}, {30'b0, busy, done}, 32'd2);
    start = noisy;
    for (int i = 1; i < XLEN; i++) begin
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      @(posedge clk); #1;
      check({tag, ":calc"}, {30'b0, busy, done}, 32'd2);
    end
    @(posedge clk); #1;
    check({tag, ":state@N+32"}, {30'b0, busy, done}, 32'd3);
    check({tag, ":result"}, result, exp);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":state@N+33"}, {30'b0, busy, done}, 32'd0);
    check({tag, ":hold"}, result, exp);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;

    // Reset state before any clock edge.
    #3;
    check("reset_state", {30'b0, busy, done}, 32'd0);
    check("reset_result", result, 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {30'b0, busy, done}, 32'd0);

    // Directed cases.
    run_op("mul_7xm3",     3'd0, 32'd7,        32'hFFFFFFFD, 1'b0);
    run_op("mulh_min",     3'd1, 32'h80000000, 32'h80000000, 1'b0);
    run_op("mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("mulhsu_max",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        1'b0);
    run_op("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        1'b0);
    run_op("divu_big_2",   3'd5, 32'hFFFFFFF9, 32'd2,        1'b0);
    run_op("divu_by0",     3'd5, 32'd5,        32'd0,        1'b0);
    run_op("remu_by0",     3'd7, 32'd5,        32'd0,        1'b0);
    run_op("div_by0_neg",  3'd4, 32'hFFFFFFF9, 32'd0,        1'b0);
    run_op("rem_by0_neg",  3'd6, 32'hFFFFFFF9, 32'd0,        1'b0);
    run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("rem_7_m2",     3'd6, 32'd7,        32'hFFFFFFFE, 1'b0);
    run_op("start_in_calc", 3'd3, 32'hDEADBEEF, 32'h12345678, 1'b1);

    // Random operations, biased toward divide corner operands.
    for (int k = 0; k < 24; k++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", k, f), f, a, b, 1'($urandom_range(0, 1)));
    end

    // Reset mid-CALC aborts the operation asynchronously.
    run_op("pre_reset", 3'd0, 32'h00001234, 32'h00005678, 1'b0);
    funct3 = 3'd0;
    op_a   = 32'h0000FFFF;
    op_b   = 32'h0000FFFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_state", {30'b0, busy, done}, 32'd0);
    check("abort_result", result, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("post_abort_quiet", {30'b0, busy, done}, 32'd0);
    end
    run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
